// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    PAUSE,
    POINT,
    GAME_OVER
  } match_state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_frame_timer.sv
// Frame-pulse counter with a runtime terminal count; shared by serve delay
// and game-over hold.
module frame_timer #(
  parameter int CNTW = 8
) (
  input  logic            clk_pix,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            frame,
  input  logic [CNTW-1:0] tc,
  output logic            done
);

  logic [CNTW-1:0] cnt;

  assign done = (cnt == tc);

  // Holding at terminal count keeps the counter from ever wrapping.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (en && frame && !done) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: owns scores, serve direction, serve delay, pause
// and game-over hold. Outputs are registered from the next state.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int SCOREW      = 4,
  parameter int SERVE_DELAY = 60,
  parameter int OVER_HOLD   = 180
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              frame,
  input  logic              sig_ctrl,
  input  logic              lft_col,
  input  logic              rgt_col,
  output logic              ball_run,
  output logic              ball_rst,
  output logic              serve_dir,
  output logic              demo,
  output logic [SCOREW-1:0] p1_score,
  output logic [SCOREW-1:0] p2_score,
  output logic              game_over,
  output logic              winner
);

  localparam int CNTW = $clog2(max_int(SERVE_DELAY, OVER_HOLD) + 1);
  localparam logic [SCOREW-1:0] WIN = SCOREW'(WIN_SCORE);

  match_state_t state, nxt;
  logic         timer_done;
  logic [CNTW-1:0] timer_tc;

  function automatic logic [SCOREW-1:0] sat_inc(input logic [SCOREW-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  assign timer_tc = (state == GAME_OVER) ? CNTW'(OVER_HOLD) : CNTW'(SERVE_DELAY);

  frame_timer #(.CNTW(CNTW)) u_timer (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .clr     (nxt != state),
    .en      ((state == SERVE) || (state == GAME_OVER)),
    .frame   (frame),
    .tc      (timer_tc),
    .done    (timer_done)
  );

  // NOTE: nxt gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (sig_ctrl) nxt = SERVE;
      SERVE:     if (timer_done) nxt = PLAY;
      PLAY: begin
        if (lft_col || rgt_col) nxt = POINT;
        else if (sig_ctrl)      nxt = PAUSE;
      end
      PAUSE:     if (sig_ctrl) nxt = PLAY;
      POINT: begin
        if ((p1_score == WIN) || (p2_score == WIN)) nxt = GAME_OVER;
        else                                        nxt = SERVE;
      end
      GAME_OVER: if (timer_done) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ball_run  <= 1'b1;
      ball_rst  <= 1'b0;
      demo      <= 1'b1;
      game_over <= 1'b0;
    end else begin
      state     <= nxt;
      ball_run  <= (nxt == IDLE) || (nxt == PLAY);
      ball_rst  <= (nxt == SERVE) && (state != SERVE);
      demo      <= (nxt == IDLE);
      game_over <= (nxt == GAME_OVER);
    end
  end

  // Collisions are only looked at in PLAY, so a held level scores once.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      p1_score  <= '0;
      p2_score  <= '0;
      serve_dir <= DIR_RIGHT;
      winner    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sig_ctrl) begin
          p1_score  <= '0;
          p2_score  <= '0;
          serve_dir <= DIR_RIGHT;
        end
        PLAY: begin
          if (lft_col) begin
            p2_score  <= sat_inc(p2_score);
            serve_dir <= DIR_LEFT;
          end else if (rgt_col) begin
            p1_score  <= sat_inc(p1_score);
            serve_dir <= DIR_RIGHT;
          end
        end
        POINT: if (nxt == GAME_OVER) winner <= (p1_score != WIN);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed table, corner sequences
// and randomized play against a countdown-based reference model.
module tb_pong_match_ctrl;

  localparam int WIN_SCORE = 3, SCOREW = 4, SERVE_DELAY = 4, OVER_HOLD = 5;
  localparam int PH_DEMO = 0, PH_SERVE = 1, PH_PLAY = 2, PH_PAUSE = 3,
                 PH_POINT = 4, PH_OVER = 5;

  logic clk_pix = 1'b0, rst_n = 1'b0;
  logic frame = 1'b0, sig_ctrl = 1'b0, lft_col = 1'b0, rgt_col = 1'b0;
  logic ball_run, ball_rst, serve_dir, demo, game_over, winner;
  logic [SCOREW-1:0] p1_score, p2_score;

  pong_match_ctrl #(
    .WIN_SCORE(WIN_SCORE), .SCOREW(SCOREW),
    .SERVE_DELAY(SERVE_DELAY), .OVER_HOLD(OVER_HOLD)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .sig_ctrl(sig_ctrl),
    .lft_col(lft_col), .rgt_col(rgt_col), .ball_run(ball_run),
    .ball_rst(ball_rst), .serve_dir(serve_dir), .demo(demo),
    .p1_score(p1_score), .p2_score(p2_score), .game_over(game_over),
    .winner(winner)
  );

  always #5 clk_pix = ~clk_pix;

  int vectors = 0, miscompares = 0, cyc = 0;

  // Reference model: phase plus frames-remaining countdown.
  int m_ph, m_wait, m_p1, m_p2;
  logic m_dir, m_win, m_rst;

  task automatic model_reset();
    m_ph = PH_DEMO; m_wait = 0; m_p1 = 0; m_p2 = 0;
    m_dir = 1'b0; m_win = 1'b0; m_rst = 1'b0;
  endtask

  task automatic model_edge(input logic c, l, r, f);
    int prev;
    prev = m_ph;
    case (m_ph)
      PH_DEMO: if (c) begin m_p1 = 0; m_p2 = 0; m_dir = 1'b0; m_ph = PH_SERVE; m_wait = SERVE_DELAY; end
      PH_SERVE: if (m_wait == 0) m_ph = PH_PLAY; else if (f) m_wait--;
      PH_PLAY: begin
        if (l) begin if (m_p2 < 15) m_p2++; m_dir = 1'b1; m_ph = PH_POINT; end
        else if (r) begin if (m_p1 < 15) m_p1++; m_dir = 1'b0; m_ph = PH_POINT; end
        else if (c) m_ph = PH_PAUSE;
      end
      PH_PAUSE: if (c) m_ph = PH_PLAY;
      PH_POINT: begin
        if (m_p1 == WIN_SCORE) begin m_ph = PH_OVER; m_win = 1'b0; m_wait = OVER_HOLD; end
        else if (m_p2 == WIN_SCORE) begin m_ph = PH_OVER; m_win = 1'b1; m_wait = OVER_HOLD; end
        else begin m_ph = PH_SERVE; m_wait = SERVE_DELAY; end
      end
      PH_OVER: if (m_wait == 0) m_ph = PH_DEMO; else if (f) m_wait--;
      default: m_ph = PH_DEMO;
    endcase
    m_rst = (m_ph == PH_SERVE) && (prev != PH_SERVE);
  endtask

  function automatic logic [13:0] expv();
    return {(m_ph == PH_DEMO) || (m_ph == PH_PLAY), m_rst, m_dir, m_ph == PH_DEMO,
            m_ph == PH_OVER, m_win, 4'(m_p1), 4'(m_p2)};
  endfunction

  function automatic logic [13:0] got();
    return {ball_run, ball_rst, serve_dir, demo, game_over, winner, p1_score, p2_score};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic c, l, r, f);
    sig_ctrl = c; lft_col = l; rgt_col = r; frame = f;
    @(posedge clk_pix);
    model_edge(c, l, r, f);
    @(negedge clk_pix);
    cyc++;
    check("model", 32'(got()), 32'(expv()));
  endtask

  task automatic tick(input logic c, l, r);
    step(c, l, r, (cyc % 10) == 9);
  endtask

  task automatic wait_play(input int budget);
    int n;
    n = 0;
    while (m_ph != PH_PLAY && n < budget) begin tick(0, 0, 0); n++; end
    if (m_ph != PH_PLAY) check("wait_play_timeout", 32'(m_ph), 32'(PH_PLAY));
  endtask

  typedef struct {
    logic c, l, r, f;
    logic run, rst, dmo;
    logic [3:0] p2;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int frames, pulses, pulse_at, n;

    tbl[0] = '{c:0, l:0, r:0, f:0, run:1, rst:0, dmo:1, p2:0};
    tbl[1] = '{c:0, l:0, r:0, f:1, run:1, rst:0, dmo:1, p2:0};
    tbl[2] = '{c:1, l:0, r:0, f:0, run:0, rst:1, dmo:0, p2:0};
    tbl[3] = '{c:0, l:1, r:0, f:0, run:0, rst:0, dmo:0, p2:0};
    tbl[4] = '{c:1, l:0, r:1, f:0, run:0, rst:0, dmo:0, p2:0};
    tbl[5] = '{c:0, l:0, r:0, f:0, run:0, rst:0, dmo:0, p2:0};

    model_reset();
    repeat (3) @(negedge clk_pix);
    rst_n = 1'b1;
    check("reset", 32'(got()), 32'(14'b1_0_0_1_0_0_0000_0000));

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].l, tbl[i].r, tbl[i].f);
      check($sformatf("table[%0d]", i), {28'd0, ball_run, ball_rst, demo, p2_score[0]},
            {28'd0, tbl[i].run, tbl[i].rst, tbl[i].dmo, tbl[i].p2[0]});
    end
    check("serve_dir_start", 32'(serve_dir), 32'd0);

    // Serve lasts exactly SERVE_DELAY frames.
    frames = 0; n = 0;
    while (!ball_run && n < 200) begin
      tick(0, 0, 0); n++;
      if (frame && !ball_run) frames++;
    end
    check("serve_frames", 32'(frames), 32'(SERVE_DELAY));

    // Held left collision scores once, ball_rst two cycles after rise.
    pulses = 0; pulse_at = -1;
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 0);
      if (ball_rst) begin pulses++; pulse_at = i; end
    end
    check("lft_p2", 32'(p2_score), 32'd1);
    check("lft_dir", 32'(serve_dir), 32'd1);
    check("lft_pulses", 32'(pulses), 32'd1);
    check("lft_pulse_at", 32'(pulse_at), 32'd1);

    // Simultaneous left, right and ctrl: left wins, no pause.
    wait_play(200);
    tick(1, 1, 1);
    check("simul_p2", 32'(p2_score), 32'd2);
    check("simul_p1", 32'(p1_score), 32'd0);
    tick(0, 0, 0);
    check("simul_serve", 32'(ball_rst), 32'd1);

    // Pause ignores frames and collisions.
    wait_play(200);
    tick(1, 0, 0);
    check("pause_run", 32'(ball_run), 32'd0);
    for (int i = 0; i < 25; i++) tick(0, 0, 1);
    check("pause_p1", 32'(p1_score), 32'd0);
    check("pause_still", 32'(ball_run), 32'd0);
    tick(1, 0, 0);
    check("resume_run", 32'(ball_run), 32'd1);

    // P1 wins; ctrl during hold ignored; scores retained into demo.
    for (int k = 0; k < 3; k++) begin wait_play(200); tick(0, 0, 1); end
    tick(0, 0, 0);
    check("win_over", 32'(game_over), 32'd1);
    check("win_winner", 32'(winner), 32'd0);
    tick(1, 0, 0);
    check("hold_ctrl_ignored", 32'(game_over), 32'd1);
    n = 0;
    while (!demo && n < 200) begin tick(0, 0, 0); n++; end
    check("back_to_demo", 32'(demo), 32'd1);
    check("score_retained", 32'(p1_score), 32'd3);

    // Asynchronous reset mid-serve, between clock edges.
    tick(1, 0, 0);
    repeat (3) tick(0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(got()), 32'(14'b1_0_0_1_0_0_0000_0000));
    model_reset();
    @(negedge clk_pix);
    rst_n = 1'b1;

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++)
      tick(($urandom % 16) == 0, ($urandom % 10) == 0, ($urandom % 10) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
